// File: rtl/fetch_unit.sv
// Two-state fetch unit: request an instruction word, hold it in IR until accepted, then steer the PC (sequential, branch or jump).
// Optional performance counters are enabled by defining FETCH_PERF_EN.
module fetch_unit (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    output logic [31:0] IR,
    output logic        IR_valid,
    input  logic        IR_ready,
    input  logic        Jump,
    input  logic [2:0]  condition,
    input  logic        Zero,
    input  logic        Sign,
`ifdef FETCH_PERF_EN
    output logic [31:0] taken_cnt,
    output logic [31:0] stall_cnt,
`endif
    output logic [31:0] PC
);

    typedef enum logic {
        S_FETCH = 1'b0,
        S_ISSUE = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] seq_pc;
    logic [31:0] br_off;
    logic [31:0] next_pc;
    logic        br_taken;
    logic        accept;

    // State register; reset wins over any ack or accept in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            pc_q    <= 32'h0000_0000;
            ir_q    <= 32'h0000_0000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: if (imem_ack) state_d = S_ISSUE;
            S_ISSUE: if (IR_ready) state_d = S_FETCH;
            default: state_d = S_FETCH;
        endcase
    end

    always_comb begin
        imem_req  = (state_q == S_FETCH);
        IR_valid  = (state_q == S_ISSUE);
        imem_addr = pc_q;
        PC        = pc_q;
        IR        = ir_q;
    end

    // Control inputs only matter in the accepting cycle.
    always_comb begin
        accept = (state_q == S_ISSUE) && IR_ready;
        seq_pc = pc_q + 32'd4;
        br_off = {{14{ir_q[15]}}, ir_q[15:0], 2'b00};
        case (condition)
            3'b001:  br_taken = Zero;
            3'b010:  br_taken = !Zero;
            3'b011:  br_taken = !Sign;
            3'b110:  br_taken = Sign;
            3'b101:  br_taken = Sign | Zero;
            3'b100:  br_taken = !Sign & !Zero;
            default: br_taken = 1'b0;
        endcase
        if (Jump) begin
            next_pc = {seq_pc[31:28], ir_q[25:0], 2'b00};
        end else if (br_taken) begin
            next_pc = seq_pc + br_off;
        end else begin
            next_pc = seq_pc;
        end
    end

    always_comb begin
        pc_d = pc_q;
        ir_d = ir_q;
        if ((state_q == S_FETCH) && imem_ack) begin
            ir_d = imem_data;
        end
        if (accept) begin
            pc_d = next_pc;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] taken_cnt_q, taken_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        taken_cnt_d = taken_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (accept && (next_pc != seq_pc)) begin
            taken_cnt_d = taken_cnt_q + 32'd1;
        end
        if ((state_q == S_FETCH) && !imem_ack) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            taken_cnt_q <= 32'd0;
            stall_cnt_q <= 32'd0;
        end else begin
            taken_cnt_q <= taken_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign taken_cnt = taken_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif

endmodule
